// File: rtl/tag_scoreboard_if.sv
// Dispatch/completion/retire bundle for the tag scoreboard.
// master = dispatch/FU/retire side, slave = the scoreboard itself.
interface tag_scoreboard_if #(
    parameter int NUM_TAGS = 10,
    parameter int NUM_CPL  = 2,
    parameter int TAG_W    = 5
);
    logic                     alloc_req;
    logic                     alloc_ready;
    logic [TAG_W-1:0]         alloc_tag;
    logic [NUM_CPL-1:0]       cpl_valid;
    logic [NUM_CPL*TAG_W-1:0] cpl_tag;
    logic                     free_valid;
    logic [TAG_W-1:0]         free_tag;
    logic [NUM_TAGS-1:0]      done_flags;
    logic [TAG_W:0]           free_count;
    logic                     err;

    modport master (
        output alloc_req, cpl_valid, cpl_tag, free_valid, free_tag,
        input  alloc_ready, alloc_tag, done_flags, free_count, err
    );

    modport slave (
        input  alloc_req, cpl_valid, cpl_tag, free_valid, free_tag,
        output alloc_ready, alloc_tag, done_flags, free_count, err
    );
endinterface

// File: rtl/tag_scoreboard.sv
// Physical result-tag allocator and completion tracker driving the issue-queue wakeup bus.
// Optional macro TAG_SCOREBOARD_BYPASS_EN forwards this cycle's legal completions onto done_flags.
module tag_scoreboard #(
    parameter int NUM_TAGS = 10,
    parameter int NUM_CPL  = 2,
    parameter int TAG_W    = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    tag_scoreboard_if.slave sb
);
    logic [NUM_TAGS-1:0] alloc_vec_reg, alloc_vec_next;
    logic [NUM_TAGS-1:0] done_vec_reg, done_vec_next;
    logic [TAG_W:0]      free_count_reg, free_count_next;
    logic                err_reg, err_next;

    logic [TAG_W-1:0]    cpl_tag_arr [NUM_CPL];
    logic [NUM_TAGS-1:0] cpl_dec     [NUM_CPL];
    logic [NUM_CPL-1:0]  cpl_hit;
    logic [NUM_CPL-1:0]  cpl_dup;
    logic [NUM_CPL-1:0]  cpl_legal;
    logic [NUM_TAGS-1:0] cpl_mask;
    logic                cpl_err;

    logic [NUM_TAGS-1:0] free_dec;
    logic [NUM_TAGS-1:0] free_mask;
    logic                free_hit;
    logic                free_done;
    logic                free_err;

    logic                alloc_ready_int;
    logic                alloc_fire;
    logic [TAG_W-1:0]    alloc_tag_int;
    logic [NUM_TAGS-1:0] alloc_mask;

    // One-hot decodes only span 0..NUM_TAGS-1, so out-of-range tags decode to
    // all zeros and can never touch the state vectors.
    genvar gi, gt;
    generate
        for (gi = 0; gi < NUM_CPL; gi++) begin : g_cpl
            logic [NUM_TAGS-1:0] dec;
            assign cpl_tag_arr[gi] = sb.cpl_tag[gi*TAG_W +: TAG_W];
            for (gt = 0; gt < NUM_TAGS; gt++) begin : g_dec
                assign dec[gt] = sb.cpl_valid[gi] && (cpl_tag_arr[gi] == TAG_W'(gt));
            end
            assign cpl_dec[gi]   = dec;
            assign cpl_hit[gi]   = |(dec & alloc_vec_reg);
            assign cpl_legal[gi] = cpl_hit[gi] && !cpl_dup[gi];
        end

        for (gt = 0; gt < NUM_TAGS; gt++) begin : g_tag
            assign free_dec[gt]   = sb.free_valid && (sb.free_tag == TAG_W'(gt));
            assign alloc_mask[gt] = alloc_fire && (alloc_tag_int == TAG_W'(gt));
        end
    endgenerate

    // Two ports naming the same tag in one cycle are both rejected.
    always_comb begin
        cpl_dup = '0;
        for (int i = 0; i < NUM_CPL; i++) begin
            for (int j = 0; j < NUM_CPL; j++) begin
                if (i != j && sb.cpl_valid[i] && sb.cpl_valid[j] &&
                    cpl_tag_arr[i] == cpl_tag_arr[j]) begin
                    cpl_dup[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        cpl_mask = '0;
        for (int i = 0; i < NUM_CPL; i++) begin
            if (cpl_legal[i]) begin
                cpl_mask = cpl_mask | cpl_dec[i];
            end
        end
    end

    assign cpl_err = |(sb.cpl_valid & ~cpl_legal);

    // A same-cycle legal completion counts as done, so complete+free together is clean.
    assign free_hit  = |(free_dec & alloc_vec_reg);
    assign free_done = |(free_dec & (done_vec_reg | cpl_mask));
    assign free_err  = sb.free_valid && !(free_hit && free_done);
    assign free_mask = free_hit ? free_dec : '0;

    // Priority encoder over registered state: scanning downward lets the lowest free index win.
    always_comb begin
        alloc_tag_int = '0;
        for (int t = NUM_TAGS - 1; t >= 0; t--) begin
            if (!alloc_vec_reg[t]) begin
                alloc_tag_int = TAG_W'(t);
            end
        end
    end

    assign alloc_ready_int = !(&alloc_vec_reg);
    assign alloc_fire      = sb.alloc_req && alloc_ready_int;

    always_comb begin
        alloc_vec_next  = (alloc_vec_reg & ~free_mask) | alloc_mask;
        done_vec_next   = (done_vec_reg | cpl_mask | free_mask) & ~alloc_mask;
        err_next        = err_reg || cpl_err || free_err;
        free_count_next = '0;
        for (int t = 0; t < NUM_TAGS; t++) begin
            free_count_next = free_count_next + (TAG_W+1)'(!alloc_vec_next[t]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_vec_reg  <= '0;
            done_vec_reg   <= '1;
            free_count_reg <= (TAG_W+1)'(NUM_TAGS);
            err_reg        <= 1'b0;
        end else begin
            alloc_vec_reg  <= alloc_vec_next;
            done_vec_reg   <= done_vec_next;
            free_count_reg <= free_count_next;
            err_reg        <= err_next;
        end
    end

    assign sb.alloc_ready = alloc_ready_int;
    assign sb.alloc_tag   = alloc_tag_int;
    assign sb.free_count  = free_count_reg;
    assign sb.err         = err_reg;

`ifdef TAG_SCOREBOARD_BYPASS_EN
    assign sb.done_flags = done_vec_reg | cpl_mask;
`else
    assign sb.done_flags = done_vec_reg;
`endif

endmodule

// File: tb/tb_tag_scoreboard.sv
// Self-checking bench for tag_scoreboard: directed vector table, hand sequences for
// pool exhaustion / errors / async reset, and randomized traffic against a tag-set model.
module tb_tag_scoreboard;
    localparam int NT = 10;
    localparam int NC = 2;
    localparam int TW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    tag_scoreboard_if #(.NUM_TAGS(NT), .NUM_CPL(NC), .TAG_W(TW)) sb_if ();

    tag_scoreboard #(.NUM_TAGS(NT), .NUM_CPL(NC), .TAG_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb_if.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: which tags are handed out, which have values, sticky error.
    bit m_alloc [NT];
    bit m_done  [NT];
    bit m_err;

    typedef struct {
        bit         areq;
        logic [1:0] cv;
        int         t0;
        int         t1;
        bit         fv;
        int         ft;
        logic [9:0] e_done;
        int         e_fc;
        bit         e_err;
        int         e_tag;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int m_free_count();
        int n = 0;
        for (int t = 0; t < NT; t++) if (!m_alloc[t]) n++;
        return n;
    endfunction

    function automatic int m_lowest_free();
        for (int t = 0; t < NT; t++) if (!m_alloc[t]) return t;
        return 0;
    endfunction

    function automatic logic [NT-1:0] m_done_bits();
        logic [NT-1:0] b = '0;
        for (int t = 0; t < NT; t++) b[t] = m_done[t];
        return b;
    endfunction

    task automatic model_reset();
        for (int t = 0; t < NT; t++) begin
            m_alloc[t] = 1'b0;
            m_done[t]  = 1'b1;
        end
        m_err = 1'b0;
    endtask

    task automatic set_idle();
        sb_if.alloc_req  = 1'b0;
        sb_if.cpl_valid  = '0;
        sb_if.cpl_tag    = '0;
        sb_if.free_valid = 1'b0;
        sb_if.free_tag   = '0;
    endtask

    task automatic check_state(input string name);
        check({name, " done_flags"}, 32'(sb_if.done_flags), 32'(m_done_bits()));
        check({name, " free_count"}, 32'(sb_if.free_count), 32'(m_free_count()));
        check({name, " alloc_ready"}, 32'(sb_if.alloc_ready), 32'(m_free_count() > 0));
        if (m_free_count() > 0)
            check({name, " alloc_tag"}, 32'(sb_if.alloc_tag), 32'(m_lowest_free()));
        check({name, " err"}, 32'(sb_if.err), 32'(m_err));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        set_idle();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_state("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    // Called at posedge+2; returns at posedge+2 of the next cycle with inputs idle.
    task automatic drive_cycle(input bit areq, input logic [1:0] cv, input int t0, input int t1,
                               input bit fv, input int ft);
        int            ct [NC];
        bit            legal [NC];
        logic [NT-1:0] lmask;
        bit            grant;
        int            gtag;
        bit            same;
        ct[0] = t0;
        ct[1] = t1;
        sb_if.alloc_req  = areq;
        sb_if.cpl_valid  = cv;
        sb_if.cpl_tag    = {TW'(t1), TW'(t0)};
        sb_if.free_valid = fv;
        sb_if.free_tag   = TW'(ft);
        #1;
        // A completion is legal if its tag is in range, handed out, and not claimed twice.
        lmask = '0;
        for (int i = 0; i < NC; i++) begin
            same = 1'b0;
            for (int j = 0; j < NC; j++)
                if (j != i && cv[j] && ct[j] == ct[i]) same = 1'b1;
            legal[i] = cv[i] && ct[i] < NT && m_alloc[ct[i]] && !same;
            if (legal[i]) lmask[ct[i]] = 1'b1;
        end
        check("pre alloc_ready", 32'(sb_if.alloc_ready), 32'(m_free_count() > 0));
        if (m_free_count() > 0)
            check("pre alloc_tag", 32'(sb_if.alloc_tag), 32'(m_lowest_free()));
`ifdef TAG_SCOREBOARD_BYPASS_EN
        check("pre done_flags", 32'(sb_if.done_flags), 32'(m_done_bits() | lmask));
`else
        check("pre done_flags", 32'(sb_if.done_flags), 32'(m_done_bits()));
`endif
        grant = areq && m_free_count() > 0;
        gtag  = m_lowest_free();
        @(posedge clk);
        for (int i = 0; i < NC; i++) begin
            if (cv[i]) begin
                if (legal[i]) m_done[ct[i]] = 1'b1;
                else          m_err = 1'b1;
            end
        end
        if (fv) begin
            if (ft < NT && m_alloc[ft]) begin
                if (!(m_done[ft] || lmask[ft])) m_err = 1'b1;
                m_alloc[ft] = 1'b0;
                m_done[ft]  = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
        if (grant) begin
            m_alloc[gtag] = 1'b1;
            m_done[gtag]  = 1'b0;
        end
        #1;
        set_idle();
        #1;
        $display("[TB] t=%0t areq=%0d cv=%b tags=%0d,%0d free=%0d/%0d -> done=%h fc=%0d rdy=%0d tag=%0d err=%0d",
                 $time, areq, cv, t0, t1, fv, ft, sb_if.done_flags, sb_if.free_count,
                 sb_if.alloc_ready, sb_if.alloc_tag, sb_if.err);
        check_state("post");
    endtask

    function automatic int pick_tag(input bit want_done);
        int q[$];
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(0, 15));
        for (int t = 0; t < NT; t++)
            if (m_alloc[t] && (!want_done || m_done[t])) q.push_back(t);
        if (q.size() == 0) return int'($urandom_range(0, NT - 1));
        return q[$urandom_range(0, q.size() - 1)];
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 2'b00, 0, 0, 1'b0, 0, 10'h3FE, 9, 1'b0, 1};
        tbl[1] = '{1'b1, 2'b00, 0, 0, 1'b0, 0, 10'h3FC, 8, 1'b0, 2};
        tbl[2] = '{1'b1, 2'b00, 0, 0, 1'b0, 0, 10'h3F8, 7, 1'b0, 3};
        tbl[3] = '{1'b0, 2'b11, 2, 0, 1'b0, 0, 10'h3FD, 7, 1'b0, 3};
        tbl[4] = '{1'b1, 2'b01, 1, 0, 1'b1, 0, 10'h3F7, 7, 1'b0, 0};
        tbl[5] = '{1'b0, 2'b00, 0, 0, 1'b1, 1, 10'h3F7, 8, 1'b0, 0};
        tbl[6] = '{1'b0, 2'b10, 0, 3, 1'b1, 3, 10'h3FF, 9, 1'b0, 0};
        tbl[7] = '{1'b0, 2'b01, 7, 0, 1'b0, 0, 10'h3FF, 9, 1'b1, 0};
        tbl[8] = '{1'b0, 2'b01, 12, 0, 1'b0, 0, 10'h3FF, 9, 1'b1, 0};

        set_idle();
        model_reset();
        do_reset();

        for (int r = 0; r < 9; r++) begin
            drive_cycle(tbl[r].areq, tbl[r].cv, tbl[r].t0, tbl[r].t1, tbl[r].fv, tbl[r].ft);
            check($sformatf("tbl[%0d] done_flags", r), 32'(sb_if.done_flags), 32'(tbl[r].e_done));
            check($sformatf("tbl[%0d] free_count", r), 32'(sb_if.free_count), 32'(tbl[r].e_fc));
            check($sformatf("tbl[%0d] alloc_ready", r), 32'(sb_if.alloc_ready), 32'(tbl[r].e_fc > 0));
            check($sformatf("tbl[%0d] alloc_tag", r), 32'(sb_if.alloc_tag), 32'(tbl[r].e_tag));
            check($sformatf("tbl[%0d] err", r), 32'(sb_if.err), 32'(tbl[r].e_err));
        end

        // Exhaust the pool, stall, then recycle tag 4 (not allocatable in its free cycle).
        do_reset();
        for (int k = 0; k < NT; k++) drive_cycle(1'b1, 2'b00, 0, 0, 1'b0, 0);
        check("exhaust alloc_ready", 32'(sb_if.alloc_ready), 32'd0);
        check("exhaust free_count", 32'(sb_if.free_count), 32'd0);
        drive_cycle(1'b1, 2'b00, 0, 0, 1'b0, 0);
        check("stall free_count", 32'(sb_if.free_count), 32'd0);
        check("stall err", 32'(sb_if.err), 32'd0);
        drive_cycle(1'b1, 2'b00, 0, 0, 1'b1, 4);
        check("recycle alloc_ready", 32'(sb_if.alloc_ready), 32'd1);
        check("recycle alloc_tag", 32'(sb_if.alloc_tag), 32'd4);
        check("recycle done_flags", 32'(sb_if.done_flags), 32'h010);
        drive_cycle(1'b1, 2'b00, 0, 0, 1'b0, 0);
        check("reissue free_count", 32'(sb_if.free_count), 32'd0);
        check("reissue done_flags", 32'(sb_if.done_flags), 32'h000);

        // Error cases, each from a fresh reset.
        do_reset();
        drive_cycle(1'b0, 2'b01, 7, 0, 1'b0, 0);
        check("err unalloc err", 32'(sb_if.err), 32'd1);
        check("err unalloc done", 32'(sb_if.done_flags), 32'h3FF);
        do_reset();
        drive_cycle(1'b0, 2'b10, 0, 12, 1'b0, 0);
        check("err range err", 32'(sb_if.err), 32'd1);
        check("err range fc", 32'(sb_if.free_count), 32'd10);
        do_reset();
        drive_cycle(1'b1, 2'b00, 0, 0, 1'b0, 0);
        drive_cycle(1'b0, 2'b11, 0, 0, 1'b0, 0);
        check("err dup err", 32'(sb_if.err), 32'd1);
        check("err dup done", 32'(sb_if.done_flags), 32'h3FE);
        do_reset();
        drive_cycle(1'b0, 2'b00, 0, 0, 1'b1, 5);
        check("err free_unalloc err", 32'(sb_if.err), 32'd1);
        do_reset();
        drive_cycle(1'b1, 2'b00, 0, 0, 1'b0, 0);
        drive_cycle(1'b0, 2'b00, 0, 0, 1'b1, 0);
        check("err free_notdone err", 32'(sb_if.err), 32'd1);
        check("err free_notdone fc", 32'(sb_if.free_count), 32'd10);

        // Asynchronous reset in mid-cycle with live allocations.
        do_reset();
        for (int k = 0; k < 6; k++) drive_cycle(1'b1, 2'b00, 0, 0, 1'b0, 0);
        drive_cycle(1'b0, 2'b11, 1, 3, 1'b0, 0);
        check("midrst pre done", 32'(sb_if.done_flags), 32'h3CA);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst done_flags", 32'(sb_if.done_flags), 32'h3FF);
        check("midrst free_count", 32'(sb_if.free_count), 32'd10);
        check("midrst alloc_ready", 32'(sb_if.alloc_ready), 32'd1);
        check("midrst alloc_tag", 32'(sb_if.alloc_tag), 32'd0);
        check("midrst err", 32'(sb_if.err), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;

        // Randomized traffic against the model, with periodic resets to clear err.
        for (int k = 0; k < 400; k++) begin
            bit         areq;
            logic [1:0] cv;
            int         t0, t1, ft;
            bit         fv;
            if (k % 60 == 59) do_reset();
            areq = 1'($urandom_range(0, 1));
            cv   = 2'($urandom_range(0, 3));
            t0   = pick_tag(1'b0);
            t1   = pick_tag(1'b0);
            fv   = ($urandom_range(0, 2) == 0);
            ft   = pick_tag(1'b1);
            drive_cycle(areq, cv, t0, t1, fv, ft);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
